radix4div: RTL and testbench

- Sequential unsigned divider that inverts the radix-4 Booth multiplier: divides a 2N-bit value (a product-width operand) by an N-bit divisor.
- Retires 2 quotient bits per clock using two chained restoring steps per cycle (radix-4), so N iterations per division.
- Sits beside radix4acc in the arithmetic datapath, with a start/busy/done handshake to the controlling FSM.

---
 rtl/radix4_pkg.sv | 13 +
 rtl/radix4div_step.sv | 22 ++
 rtl/radix4div.sv | 102 ++++++++++
 tb/tb_radix4div.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/radix4_pkg.sv
// Shared definitions for the radix-4 arithmetic blocks.
// Holds the divider FSM state encoding and the default operand width.
package radix4_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/radix4div_step.sv
// One restoring division step: shift one dividend bit into the partial
// remainder, and subtract the divisor when the shifted value covers it.
module radix4div_step
    import radix4_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N:0]   rem,
    input  logic         inbit,
    input  logic [N-1:0] d,
    output logic [N:0]   rem_next,
    output logic         qbit
);

    logic [N+1:0] t;

    assign t    = {rem, inbit};
    assign qbit = (t >= {2'b00, d});
    // The invariant rem < d keeps the step result below 2^N, so narrowing it to N+1 bits loses nothing
    assign rem_next = qbit ? (N+1)'(t - {2'b00, d}) : t[N:0];

endmodule

// File: rtl/radix4div.sv
// Sequential 2N/N unsigned divider, two restoring steps per clock.
// Results are valid from the one-cycle done pulse and held until the next result.
module radix4div
    import radix4_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] p,
    input  logic [N-1:0]   y,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           div_by_zero
);

    localparam int CW = $clog2(N);

    state_t         state, state_d;
    logic [2*N-1:0] dvd;
    logic [N-1:0]   d;
    logic [N:0]     rem, rem_a, rem_b;
    logic [2*N-3:0] qsr;
    logic [CW-1:0]  cnt;
    logic           qa, qb, accept;

    radix4div_step #(.N(N)) u_step_a (
        .rem      (rem),
        .inbit    (dvd[2*N-1]),
        .d        (d),
        .rem_next (rem_a),
        .qbit     (qa)
    );

    radix4div_step #(.N(N)) u_step_b (
        .rem      (rem_a),
        .inbit    (dvd[2*N-2]),
        .d        (d),
        .rem_next (rem_b),
        .qbit     (qb)
    );

    // DONE accepts a new start just like IDLE, giving back-to-back divisions
    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: begin
                if (start)              state_d = (y == '0) ? DONE : RUN;
                else if (state == DONE) state_d = IDLE;
            end
            RUN:     if (cnt == '0) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd         <= '0;
            d           <= '0;
            rem         <= '0;
            qsr         <= '0;
            cnt         <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvd <= p;
            d   <= y;
            rem <= '0;
            qsr <= '0;
            cnt <= CW'(N-1);
            if (y == '0) begin
                q           <= '1;
                r           <= p[N-1:0];
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            dvd <= {dvd[2*N-3:0], 2'b00};
            rem <= rem_b;
            qsr <= {qsr[2*N-5:0], qa, qb};
            cnt <= cnt - CW'(1);
            if (cnt == '0) begin
                q           <= {qsr, qa, qb};
                r           <= rem_b[N-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_radix4div.sv
// Directed and randomized checks of radix4div against an arithmetic model
// (p / y, p % y, and the divide-by-zero convention).
module tb_radix4div;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [2*N-1:0] p = '0;
    logic [N-1:0]   y = '0;
    logic           busy, done, div_by_zero;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;

    int nvec = 0;
    int nerr = 0;

    // Expected currently-held result
    logic [2*N-1:0] eq  = '0;
    logic [N-1:0]   er  = '0;
    logic           edz = 1'b0;

    radix4div #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .p           (p),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2*N-1:0] pp, input logic [N-1:0] yy);
        if (yy == '0) begin
            eq  = '1;
            er  = pp[N-1:0];
            edz = 1'b1;
        end else begin
            eq  = pp / {{N{1'b0}}, yy};
            er  = N'(pp % {{N{1'b0}}, yy});
            edz = 1'b0;
        end
    endtask

    // Called at a negedge; returns at the negedge following the start edge.
    task automatic issue(input logic [2*N-1:0] pp, input logic [N-1:0] yy);
        start = 1'b1;
        p     = pp;
        y     = yy;
        @(negedge clk);
    endtask

    // lat counts edges from the start edge (inclusive) to the cycle done is seen.
    task automatic wait_done(input bit keep, input int poke, output int lat, output int bc);
        bit held_bad;
        held_bad = 1'b0;
        lat = 1;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            if (q !== eq || r !== er || div_by_zero !== edz) held_bad = 1'b1;
            if (lat == poke) begin
                start = 1'b1;
                p     = ~p;
                y     = y + 8'd3;
            end else if (!keep) begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        if (!keep) start = 1'b0;
        chk("hold_during_run", {31'd0, held_bad}, 32'd0);
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [2*N-1:0] pp, input logic [N-1:0] yy,
                       input bit keep, input int poke, output int lat, output int bc);
        issue(pp, yy);
        wait_done(keep, poke, lat, bc);
        model(pp, yy);
        chk({tag, "_q"}, {16'd0, q}, {16'd0, eq});
        chk({tag, "_r"}, {24'd0, r}, {24'd0, er});
        chk({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    endtask

    initial begin
        int lat, bc, g;
        logic [2*N-1:0] rp;
        logic [N-1:0]   ry;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", {16'd0, q}, 32'd0);
        chk("rst_r", {24'd0, r}, 32'd0);
        chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal
        run("nom", 16'd1000, 8'd7, 1'b0, 0, lat, bc);
        chk("nom_q_lit", {16'd0, q}, 32'd142);
        chk("nom_r_lit", {24'd0, r}, 32'd6);
        chk("nom_lat", lat, 9);
        chk("nom_busy_cycles", bc, 8);
        @(negedge clk);
        chk("nom_done_1cyc", {31'd0, done}, 32'd0);

        // Extremes
        run("ext1", 16'hFFFF, 8'd1, 1'b0, 0, lat, bc);
        chk("ext1_q_lit", {16'd0, q}, 32'hFFFF);
        run("ext2", 16'hFFFF, 8'hFF, 1'b0, 0, lat, bc);
        chk("ext2_q_lit", {16'd0, q}, 32'd257);
        run("ext3", 16'd5, 8'd9, 1'b0, 0, lat, bc);
        chk("ext3_r_lit", {24'd0, r}, 32'd5);
        @(negedge clk);

        // Divide by zero, then a normal division clears the flag
        run("dz", 16'h1234, 8'd0, 1'b0, 0, lat, bc);
        chk("dz_lat", lat, 1);
        chk("dz_r_lit", {24'd0, r}, 32'h34);
        @(negedge clk);
        chk("dz_done_1cyc", {31'd0, done}, 32'd0);
        run("after_dz", 16'd100, 8'd10, 1'b0, 0, lat, bc);
        chk("after_dz_q_lit", {16'd0, q}, 32'd10);
        @(negedge clk);

        // Start while busy is ignored
        run("poke", 16'd1000, 8'd7, 1'b0, 3, lat, bc);
        chk("poke_lat", lat, 9);
        @(negedge clk);
        chk("poke_no_extra_run", {31'd0, busy}, 32'd0);

        // Start held high: back-to-back with no idle cycle
        run("b2b1", 16'd1000, 8'd7, 1'b1, 0, lat, bc);
        chk("b2b1_lat", lat, 9);
        run("b2b2", 16'd100, 8'd10, 1'b1, 0, lat, bc);
        chk("b2b2_lat", lat, 9);
        run("b2b3", 16'd4321, 8'd13, 1'b1, 0, lat, bc);
        chk("b2b3_lat", lat, 9);
        start = 1'b0;
        @(negedge clk);
        chk("b2b_idle", {30'd0, busy, done}, 32'd0);

        // Asynchronous reset mid-run
        issue(16'd1000, 8'd7);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_q", {16'd0, q}, 32'd0);
        chk("mrst_r", {24'd0, r}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_dz", {31'd0, div_by_zero}, 32'd0);
        eq = '0; er = '0; edz = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mrst_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_after_done", {31'd0, done}, 32'd0);
        run("post_rst", 16'd200, 8'd3, 1'b0, 0, lat, bc);
        chk("post_rst_q_lit", {16'd0, q}, 32'd66);
        chk("post_rst_r_lit", {24'd0, r}, 32'd2);

        // Random divisions with idle gaps; results must hold between done pulses
        for (int i = 0; i < 3000; i++) begin
            rp = 16'($urandom);
            ry = 8'($urandom_range(1, 255));
            g  = int'($urandom_range(0, 2));
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                chk("idle_hold", {7'd0, q, r, div_by_zero}, {7'd0, eq, er, edz});
            end
            run("rnd", rp, ry, 1'b0, 0, lat, bc);
            chk("rnd_lat", lat, 9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
